gate_bist_checker: RTL and testbench

- Self-checking stimulus/response engine for the two-input gate set (OR, NOT, NOR, NAND, XOR, XNOR).
- Drives all four A/B combinations onto a gate bank, waits for outputs to settle, and compares the six outputs against the expected truth table.
- Reports an error count, the first failure, and a pass/done flag.
- Sits beside the gate modules as an on-chip/in-sim checker, so gate verification does not depend on a human reading $monitor output.

---
 rtl/gate_bist_checker.sv | 200 ++++++++++++++++++++
 tb/tb_gate_bist_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_checker.sv
// ---------------------------------------------------------------------------
// gate_bist_checker
//
// Stimulus/response checker for the two-input gate bank (OR, NOT(A), NOR,
// NAND, XOR, XNOR). On start it walks {A,B} through 00, 01, 10, 11, holds
// each vector for SETTLE_CYCLES clocks so the gates can settle, then samples
// the six gate outputs for one more clock and compares them with the known
// truth table. Mismatching vectors are counted (saturating), the first
// failing vector and its bit-error mask are captured, and a done/pass pair
// summarises the sweep.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   ERR_W          width of the saturating error counter
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-high reset
//   i_start        begin a sweep; only looked at in IDLE or DONE
//   o_vec_a        A stimulus to the gate bank
//   o_vec_b        B stimulus to the gate bank
//   i_dut_y        gate outputs {OR, NOT(A), NOR, NAND, XOR, XNOR}, bit5..bit0
//   o_busy         sweep in progress
//   o_done         sweep complete; held until restart or reset
//   o_pass         meaningful only with o_done; 1 when no vector mismatched
//   o_err_count    number of mismatching vectors in the last sweep
//   o_fail_vec     {A,B} of the first failing vector
//   o_fail_mask    i_dut_y XOR expected for the first failing vector
// ---------------------------------------------------------------------------
module gate_bist_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic             o_vec_a,
   output logic             o_vec_b,
   input  logic [5:0]       i_dut_y,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [ERR_W-1:0] o_err_count,
   output logic [1:0]       o_fail_vec,
   output logic [5:0]       o_fail_mask
);

   // The settle counter has to hold SETTLE_CYCLES itself, and never drops
   // below 1 while in SETTLE, so a width of clog2(SETTLE_CYCLES+1) suffices.
   localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } checkerState_t;

   checkerState_t    r_state;
   checkerState_t    w_nextState;

   logic [1:0]       r_vec;
   logic [CNT_W-1:0] r_cnt;
   logic [ERR_W-1:0] r_errCount;
   logic [1:0]       r_failVec;
   logic [5:0]       r_failMask;
   logic             r_pass;

   logic [5:0]       w_expected;
   logic             w_mismatch;
   logic             w_startSweep;
   logic             w_settleDone;
   logic             w_lastVector;
   logic             w_errSaturated;
   logic             w_firstError;

   // Reference truth table for the gate bank, indexed by {A,B}. Bit order
   // matches i_dut_y: {OR, NOT(A), NOR, NAND, XOR, XNOR}.
   always_comb begin
      w_expected = 6'b000000;
      case (r_vec)
         2'b00:   w_expected = 6'b011101;
         2'b01:   w_expected = 6'b110110;
         2'b10:   w_expected = 6'b100110;
         2'b11:   w_expected = 6'b100001;
         default: w_expected = 6'b000000;
      endcase
   end

   // Case-inequality so that an X or Z coming back from a broken gate model
   // is treated as a miscompare rather than silently matching; hardware
   // reduces this to an ordinary inequality.
   assign w_mismatch     = (i_dut_y !== w_expected);
   assign w_startSweep   = ((r_state == IDLE) || (r_state == DONE)) && i_start;
   assign w_settleDone   = (r_cnt == CNT_ONE);
   assign w_lastVector   = (r_vec == 2'b11);
   assign w_errSaturated = &r_errCount;
   assign w_firstError   = (r_errCount == '0);

   // State register. Reset is asynchronous so a sweep can be aborted at any
   // point without waiting for the clock.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. SETTLE counts down the hold time, CHECK spends exactly
   // one cycle sampling, and the sweep ends after the 11 vector is checked.
   // start is deliberately ignored while a sweep is running.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (i_start) w_nextState = SETTLE;
         end
         SETTLE: begin
            if (w_settleDone) w_nextState = CHECK;
         end
         CHECK: begin
            if (w_lastVector) w_nextState = DONE;
            else              w_nextState = SETTLE;
         end
         DONE: begin
            if (i_start) w_nextState = SETTLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath registers: stimulus vector, settle counter and the result
   // capture. The vector only moves on the start edge and on edges leaving
   // CHECK, so the gate bank never sees a mid-vector glitch. The failure
   // snapshot is taken only for the first miscompare of a sweep, which is
   // identified by the error counter still being zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vec      <= 2'b00;
         r_cnt      <= '0;
         r_errCount <= '0;
         r_failVec  <= 2'b00;
         r_failMask <= 6'b000000;
         r_pass     <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_startSweep) begin
                  r_vec      <= 2'b00;
                  r_cnt      <= CNT_INIT;
                  r_errCount <= '0;
                  r_failVec  <= 2'b00;
                  r_failMask <= 6'b000000;
                  r_pass     <= 1'b0;
               end
            end
            SETTLE: begin
               if (!w_settleDone) r_cnt <= r_cnt - CNT_ONE;
            end
            CHECK: begin
               if (w_mismatch) begin
                  if (!w_errSaturated) r_errCount <= r_errCount + ERR_ONE;
                  if (w_firstError) begin
                     r_failVec  <= r_vec;
                     r_failMask <= i_dut_y ^ w_expected;
                  end
               end
               if (w_lastVector) begin
                  r_pass <= w_firstError && !w_mismatch;
               end else begin
                  r_vec <= r_vec + 2'd1;
                  r_cnt <= CNT_INIT;
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   // Output decode. busy and done are both derived from the state so they
   // can never be high together; pass is qualified by done so it never
   // reads as 1 while a sweep is still running.
   always_comb begin
      o_vec_a     = r_vec[1];
      o_vec_b     = r_vec[0];
      o_busy      = (r_state == SETTLE) || (r_state == CHECK);
      o_done      = (r_state == DONE);
      o_pass      = r_pass && (r_state == DONE);
      o_err_count = r_errCount;
      o_fail_vec  = r_failVec;
      o_fail_mask = r_failMask;
   end

endmodule

// File: tb/tb_gate_bist_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_bist_checker
//
// Directed bench for gate_bist_checker. A behavioural gate bank feeds the
// main instance and can be switched between a correct bank and several
// faulty ones. A second instance with a 1-bit error counter is always fed a
// fully inverted bank so counter saturation is exercised alongside.
// ---------------------------------------------------------------------------
module tb_gate_bist_checker;

   logic       clk;
   logic       rst;
   logic       start;
   int         faultMode;

   logic       vecA;
   logic       vecB;
   logic [5:0] gateY;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] errCount;
   logic [1:0] failVec;
   logic [5:0] failMask;

   logic       vecAW1;
   logic       vecBW1;
   logic [5:0] gateYW1;
   logic       busyW1;
   logic       doneW1;
   logic       passW1;
   logic [0:0] errCountW1;
   logic [1:0] failVecW1;
   logic [5:0] failMaskW1;

   int         vectorCount;
   int         missCount;

   gate_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .o_vec_a     (vecA),
      .o_vec_b     (vecB),
      .i_dut_y     (gateY),
      .o_busy      (busy),
      .o_done      (done),
      .o_pass      (pass),
      .o_err_count (errCount),
      .o_fail_vec  (failVec),
      .o_fail_mask (failMask)
   );

   gate_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(1)) dutW1 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .o_vec_a     (vecAW1),
      .o_vec_b     (vecBW1),
      .i_dut_y     (gateYW1),
      .o_busy      (busyW1),
      .o_done      (doneW1),
      .o_pass      (passW1),
      .o_err_count (errCountW1),
      .o_fail_vec  (failVecW1),
      .o_fail_mask (failMaskW1)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural gate bank with selectable faults:
   //   0 correct, 1 XOR stuck at 0, 2 NAND built as AND.
   always_comb begin
      gateY = {vecA | vecB, ~vecA, ~(vecA | vecB), ~(vecA & vecB),
               vecA ^ vecB, ~(vecA ^ vecB)};
      if (faultMode == 1) gateY[1] = 1'b0;
      if (faultMode == 2) gateY[2] = vecA & vecB;
   end

   // The narrow-counter instance always sees every output inverted.
   always_comb begin
      gateYW1 = ~{vecAW1 | vecBW1, ~vecAW1, ~(vecAW1 | vecBW1),
                  ~(vecAW1 & vecBW1), vecAW1 ^ vecBW1, ~(vecAW1 ^ vecBW1)};
   end

   // Single comparison point: counts every check and reports miscompares.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Select the gate-bank fault and pulse start for one edge. Returns 1 ns
   // after the start edge.
   task automatic applyStimulus(input int mode);
      @(negedge clk);
      faultMode = mode;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
   endtask

   // Full sweep with vector timing checks on every cycle and result checks
   // at the done edge. With midPulse set, start is raised for the edge after
   // cycle 4 to show it has no effect mid-sweep.
   task automatic runSweep(input int mode, input bit midPulse,
                           input logic [3:0] expErr, input logic [1:0] expFailVec,
                           input logic [5:0] expFailMask, input logic expPass);
      applyStimulus(mode);
      for (int e = 0; e < 12; e++) begin
         if (e > 0) begin
            tick();
            start = 1'b0;
         end
         checkOutput("vector", 32'({vecA, vecB}), 32'(e / 3));
         checkOutput("busy", 32'(busy), 32'd1);
         checkOutput("doneEarly", 32'(done), 32'd0);
         if (midPulse && e == 4) start = 1'b1;
      end
      tick();
      checkOutput("doneAt12", 32'(done), 32'd1);
      checkOutput("busyAt12", 32'(busy), 32'd0);
      checkOutput("pass", 32'(pass), 32'(expPass));
      checkOutput("errCount", 32'(errCount), 32'(expErr));
      checkOutput("failVec", 32'(failVec), 32'(expFailVec));
      checkOutput("failMask", 32'(failMask), 32'(expFailMask));
   endtask

   initial begin
      vectorCount = 0;
      missCount   = 0;
      faultMode   = 0;
      start       = 1'b0;
      rst         = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rstVec", 32'({vecA, vecB}), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstPass", 32'(pass), 32'd0);
      checkOutput("rstErr", 32'(errCount), 32'd0);
      checkOutput("rstFailVec", 32'(failVec), 32'd0);
      checkOutput("rstFailMask", 32'(failMask), 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("idleHold", 32'(busy), 32'd0);

      // Correct gate bank: clean sweep
      runSweep(0, 1'b0, 4'd0, 2'b00, 6'b000000, 1'b1);

      // Narrow counter with fully inverted gates ran in parallel
      checkOutput("w1Done", 32'(doneW1), 32'd1);
      checkOutput("w1ErrSat", 32'(errCountW1), 32'd1);
      checkOutput("w1FailVec", 32'(failVecW1), 32'b00);
      checkOutput("w1FailMask", 32'(failMaskW1), 32'b111111);
      checkOutput("w1Pass", 32'(passW1), 32'd0);

      // XOR output stuck at 0: fails on 01 and 10
      runSweep(1, 1'b0, 4'd2, 2'b01, 6'b000010, 1'b0);

      // NAND built as AND: fails on every vector
      runSweep(2, 1'b0, 4'd4, 2'b00, 6'b000100, 1'b0);

      // Asynchronous reset in the middle of a sweep
      applyStimulus(0);
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstVec", 32'({vecA, vecB}), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstDone", 32'(done), 32'd0);
      checkOutput("midRstPass", 32'(pass), 32'd0);
      checkOutput("midRstErr", 32'(errCount), 32'd0);
      checkOutput("midRstFailVec", 32'(failVec), 32'd0);
      checkOutput("midRstFailMask", 32'(failMask), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      runSweep(0, 1'b0, 4'd0, 2'b00, 6'b000000, 1'b1);

      // start pulsed mid-sweep is ignored; faulty bank leaves errors behind
      runSweep(2, 1'b1, 4'd4, 2'b00, 6'b000100, 1'b0);

      // DONE holds its results while start is low
      repeat (2) tick();
      checkOutput("doneHold", 32'(done), 32'd1);
      checkOutput("doneHoldErr", 32'(errCount), 32'd4);
      checkOutput("doneHoldMask", 32'(failMask), 32'b000100);

      // start in DONE restarts and clears results on the next edge
      applyStimulus(0);
      checkOutput("restartDone", 32'(done), 32'd0);
      checkOutput("restartBusy", 32'(busy), 32'd1);
      checkOutput("restartPass", 32'(pass), 32'd0);
      checkOutput("restartErr", 32'(errCount), 32'd0);
      checkOutput("restartMask", 32'(failMask), 32'd0);
      checkOutput("restartVec", 32'({vecA, vecB}), 32'd0);
      repeat (11) tick();
      checkOutput("restartDoneEarly", 32'(done), 32'd0);
      tick();
      checkOutput("restartDone12", 32'(done), 32'd1);
      checkOutput("restartPass12", 32'(pass), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
